mem_block_responder: RTL



---
 rtl/mem_block_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_block_responder.sv
// Block responder: splits one cache-line read or write into word beats
// on a single-port synchronous memory and pulses o_done on completion.
//
// Ports:
//   i_clk, i_arst          clock, async active-high reset
//   i_read_start           block read request (level, held until o_done)
//   i_write_start          block write request (level, wins over read)
//   i_addr                 request byte address (line offset ignored)
//   i_data_block           write-back line
//   o_data_block           last line read
//   o_done                 one-cycle completion pulse
//   o_mem_addr             word byte address
//   o_mem_re, o_mem_we     memory read / write enables
//   o_mem_wdata            memory write data
//   i_mem_rdata            memory read data, one cycle after o_mem_re
module mem_block_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512,
  parameter int WORD_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_read_start,
  input  logic                   i_write_start,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [BLOCK_WIDTH-1:0] i_data_block,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_done,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic                   o_mem_re,
  output logic                   o_mem_we,
  output logic [WORD_WIDTH-1:0]  o_mem_wdata,
  input  logic [WORD_WIDTH-1:0]  i_mem_rdata
);

  localparam int BEATS = BLOCK_WIDTH / WORD_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam int OFFW  = $clog2(BLOCK_WIDTH / 8);
  localparam int WSH   = $clog2(WORD_WIDTH / 8);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_d;
  logic                  cap;
  logic [WORD_WIDTH-1:0] wbuf [BEATS];
  logic [WORD_WIDTH-1:0] rbuf [BEATS];
  logic                  last;

  assign last = (cnt == CW'(BEATS - 1));

  // Outputs decode registered state only.
  assign o_mem_we    = (state == S_WRITE);
  assign o_mem_re    = (state == S_READ);
  assign o_done      = (state == S_DONE);
  assign o_mem_addr  = base + (ADDR_WIDTH'(cnt) << WSH);
  assign o_mem_wdata = wbuf[cnt];

  always_comb begin
    o_data_block = '0;
    for (int k = 0; k < BEATS; k++)
      o_data_block[k*WORD_WIDTH +: WORD_WIDTH] = rbuf[k];
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state <= S_IDLE;
      base  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_write_start) begin
            base  <= {i_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
            state <= S_WRITE;
          end else if (i_read_start) begin
            base  <= {i_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
            state <= S_READ;
          end
        end
        S_WRITE: begin
          cnt <= cnt + 1'b1;
          if (last) state <= S_DONE;
        end
        S_READ: begin
          cnt <= cnt + 1'b1;
          if (last) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int k = 0; k < BEATS; k++) wbuf[k] <= '0;
    end else if (state == S_IDLE && i_write_start) begin
      for (int k = 0; k < BEATS; k++)
        wbuf[k] <= i_data_block[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Read data lands one cycle after issue; cnt_d remembers its slot.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cap   <= 1'b0;
      cnt_d <= '0;
      for (int k = 0; k < BEATS; k++) rbuf[k] <= '0;
    end else begin
      cap   <= (state == S_READ);
      cnt_d <= cnt;
      if (cap) rbuf[cnt_d] <= i_mem_rdata;
    end
  end

endmodule
